// File: rtl/dap_arb_pkg.sv
// Shared types for the DAP stream arbiter: port ids, FSM state encodings, pad byte, length width.
// DAP_ARB_TIMEOUT_EN adds the PAD/FLUSH request states used by the mid-packet stall timeout.
package dap_arb_pkg;
    localparam int unsigned LEN_W    = 12;
    localparam logic [7:0]  PAD_BYTE = 8'hFF;

    typedef logic port_id_t;

    typedef enum logic [2:0] {
        RQ_IDLE,
        RQ_FWD0,
        RQ_FWD1
`ifdef DAP_ARB_TIMEOUT_EN
        ,
        RQ_PAD,
        RQ_FLUSH
`endif
    } rq_state_e;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_FWD,
        RS_DROP
    } rs_state_e;

    // A zero-length response still carries one byte on the stream.
    function automatic logic [LEN_W-1:0] rsp_beats(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction
endpackage

// File: rtl/dap_stream_arbiter_if.sv
// Stream bundle around the DAP arbiter: two request inputs, DAP command/response, two response outputs.
interface dap_stream_arbiter_if;
    import dap_arb_pkg::*;

    logic             s0_tvalid, s0_tready, s0_tlast;
    logic [7:0]       s0_tdata;
    logic             s1_tvalid, s1_tready, s1_tlast;
    logic [7:0]       s1_tdata;
    logic             m_tvalid, m_tready, m_tlast;
    logic [7:0]       m_tdata;
    logic             rsp_tvalid, rsp_tready;
    logic [7:0]       rsp_tdata;
    logic [LEN_W-1:0] rsp_tlen;
    logic             r0_tvalid, r0_tready;
    logic [7:0]       r0_tdata;
    logic [LEN_W-1:0] r0_tlen;
    logic             r1_tvalid, r1_tready;
    logic [7:0]       r1_tdata;
    logic [LEN_W-1:0] r1_tlen;
    logic [7:0]       drop_cnt;

    modport slave (
        input  s0_tvalid, s0_tdata, s0_tlast, output s0_tready,
        input  s1_tvalid, s1_tdata, s1_tlast, output s1_tready,
        output m_tvalid, m_tdata, m_tlast,    input  m_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tlen, output rsp_tready,
        output r0_tvalid, r0_tdata, r0_tlen,  input  r0_tready,
        output r1_tvalid, r1_tdata, r1_tlen,  input  r1_tready,
        output drop_cnt
    );

    modport master (
        output s0_tvalid, s0_tdata, s0_tlast, input  s0_tready,
        output s1_tvalid, s1_tdata, s1_tlast, input  s1_tready,
        input  m_tvalid, m_tdata, m_tlast,    output m_tready,
        output rsp_tvalid, rsp_tdata, rsp_tlen, input rsp_tready,
        input  r0_tvalid, r0_tdata, r0_tlen,  output r0_tready,
        input  r1_tvalid, r1_tdata, r1_tlen,  output r1_tready,
        input  drop_cnt
    );
endinterface

// File: rtl/dap_arb_order_fifo.sv
// Grant-order FIFO: one port id per outstanding request packet, popped when its response completes.
module dap_arb_order_fifo
    import dap_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_push,
    input  port_id_t i_push_id,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output port_id_t o_head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    port_id_t       r_mem [DEPTH];
    logic [PTR_W:0] r_wptr, r_rptr;
    logic           w_push, w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_push_id;
    end

    // Extra pointer bit separates full from empty when the index bits match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rptr[PTR_W-1:0]];
endmodule

// File: rtl/dap_stream_arbiter.sv
// Packet-atomic arbiter sharing the DAP command stream between two requesters and routing responses back.
// Optional DAP_ARB_TIMEOUT_EN: pad and flush a request packet stalled for TIMEOUT_CYCLES.
module dap_stream_arbiter
    import dap_arb_pkg::*;
#(
    parameter int unsigned ORDER_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                 hclk,
    input logic                 hresetn,
    dap_stream_arbiter_if.slave dap
);
    if (ORDER_DEPTH < 2 || (ORDER_DEPTH & (ORDER_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("dap_stream_arbiter: ORDER_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
    end

    rq_state_e        r_rq_state, w_rq_next;
    rs_state_e        r_rs_state, w_rs_next;
    port_id_t         r_last_grant, w_grant_id, r_rsp_id, w_fifo_head;
    logic             w_grant, w_pop, w_fifo_full, w_fifo_empty;
    logic             w_sel_tvalid, w_sel_tlast, w_rsp_beat, w_rsp_last;
    logic [LEN_W-1:0] r_rsp_cnt, r_rsp_len;
    logic [7:0]       r_drop_cnt;

    // Between grant and IDLE, last_grant names the port that owns the command stream.
    assign w_sel_tvalid = r_last_grant ? dap.s1_tvalid : dap.s0_tvalid;
    assign w_sel_tlast  = r_last_grant ? dap.s1_tlast  : dap.s0_tlast;

    dap_arb_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order_fifo (
        .i_clk     (hclk),
        .i_rst_n   (hresetn),
        .i_push    (w_grant),
        .i_push_id (w_grant_id),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_fifo_head)
    );

    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = r_last_grant;
        if (r_rq_state == RQ_IDLE && !w_fifo_full) begin
            if (dap.s0_tvalid && dap.s1_tvalid) begin
                w_grant    = 1'b1;
                w_grant_id = ~r_last_grant;
            end else if (dap.s0_tvalid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b0;
            end else if (dap.s1_tvalid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b1;
            end
        end
    end

`ifdef DAP_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [STALL_W-1:0] r_stall;
    logic               w_in_fwd, w_stall_hit;

    assign w_in_fwd    = (r_rq_state == RQ_FWD0) || (r_rq_state == RQ_FWD1);
    assign w_stall_hit = !w_sel_tvalid && (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)                                r_stall <= '0;
        else if (!w_in_fwd || w_sel_tvalid && dap.m_tready) r_stall <= '0;
        else if (!w_sel_tvalid)                      r_stall <= r_stall + STALL_W'(1);
    end
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rq_state   <= RQ_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_rq_state <= w_rq_next;
            if (w_grant) r_last_grant <= w_grant_id;
        end
    end

    always_comb begin
        w_rq_next = r_rq_state;
        unique case (r_rq_state)
            RQ_IDLE: if (w_grant) w_rq_next = w_grant_id ? RQ_FWD1 : RQ_FWD0;
            RQ_FWD0, RQ_FWD1: begin
                if (w_sel_tvalid && dap.m_tready && w_sel_tlast) w_rq_next = RQ_IDLE;
`ifdef DAP_ARB_TIMEOUT_EN
                else if (w_stall_hit) w_rq_next = RQ_PAD;
`endif
            end
`ifdef DAP_ARB_TIMEOUT_EN
            RQ_PAD:   if (dap.m_tready) w_rq_next = RQ_FLUSH;
            RQ_FLUSH: if (w_sel_tvalid && w_sel_tlast) w_rq_next = RQ_IDLE;
`endif
            default: w_rq_next = RQ_IDLE;
        endcase
    end

    always_comb begin
        dap.s0_tready = 1'b0;
        dap.s1_tready = 1'b0;
        dap.m_tvalid  = 1'b0;
        dap.m_tdata   = '0;
        dap.m_tlast   = 1'b0;
        unique case (r_rq_state)
            RQ_FWD0: begin
                dap.m_tvalid  = dap.s0_tvalid;
                dap.m_tdata   = dap.s0_tdata;
                dap.m_tlast   = dap.s0_tlast;
                dap.s0_tready = dap.m_tready;
            end
            RQ_FWD1: begin
                dap.m_tvalid  = dap.s1_tvalid;
                dap.m_tdata   = dap.s1_tdata;
                dap.m_tlast   = dap.s1_tlast;
                dap.s1_tready = dap.m_tready;
            end
`ifdef DAP_ARB_TIMEOUT_EN
            RQ_PAD: begin
                dap.m_tvalid = 1'b1;
                dap.m_tdata  = PAD_BYTE;
                dap.m_tlast  = 1'b1;
            end
            RQ_FLUSH: begin
                dap.s0_tready = !r_last_grant;
                dap.s1_tready = r_last_grant;
            end
`endif
            default: ;
        endcase
    end

    assign w_rsp_beat = dap.rsp_tvalid && dap.rsp_tready;
    assign w_rsp_last = w_rsp_beat && (r_rsp_cnt == LEN_W'(1));
    assign w_pop      = (r_rs_state == RS_FWD) && w_rsp_last;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_rs_state <= RS_IDLE;
        else          r_rs_state <= w_rs_next;
    end

    always_comb begin
        w_rs_next = r_rs_state;
        unique case (r_rs_state)
            RS_IDLE: if (dap.rsp_tvalid) w_rs_next = w_fifo_empty ? RS_DROP : RS_FWD;
            RS_FWD, RS_DROP: if (w_rsp_last) w_rs_next = RS_IDLE;
            default: w_rs_next = RS_IDLE;
        endcase
    end

    // The first response byte is only inspected in IDLE; it is consumed from FWD/DROP.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rsp_cnt  <= '0;
            r_rsp_len  <= '0;
            r_rsp_id   <= 1'b0;
            r_drop_cnt <= '0;
        end else if (r_rs_state == RS_IDLE) begin
            if (dap.rsp_tvalid) begin
                r_rsp_cnt <= rsp_beats(dap.rsp_tlen);
                r_rsp_len <= dap.rsp_tlen;
                r_rsp_id  <= w_fifo_head;
                if (w_fifo_empty && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (w_rsp_beat) begin
            r_rsp_cnt <= r_rsp_cnt - LEN_W'(1);
        end
    end

    always_comb begin
        dap.rsp_tready = 1'b0;
        dap.r0_tvalid  = 1'b0;
        dap.r0_tdata   = '0;
        dap.r0_tlen    = '0;
        dap.r1_tvalid  = 1'b0;
        dap.r1_tdata   = '0;
        dap.r1_tlen    = '0;
        unique case (r_rs_state)
            RS_FWD: begin
                if (r_rsp_id) begin
                    dap.r1_tvalid  = dap.rsp_tvalid;
                    dap.r1_tdata   = dap.rsp_tdata;
                    dap.r1_tlen    = r_rsp_len;
                    dap.rsp_tready = dap.r1_tready;
                end else begin
                    dap.r0_tvalid  = dap.rsp_tvalid;
                    dap.r0_tdata   = dap.rsp_tdata;
                    dap.r0_tlen    = r_rsp_len;
                    dap.rsp_tready = dap.r0_tready;
                end
            end
            RS_DROP: dap.rsp_tready = 1'b1;
            default: ;
        endcase
    end

    assign dap.drop_cnt = r_drop_cnt;
endmodule
